// File: rtl/fsmc_text_console.sv
// Text console register block behind the FSMC bus slave.
// Streams characters into the VGA char buffer with cursor, CR/LF and a screen-fill engine.
module fsmc_text_console #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int COLS     = 160,
    parameter int ROWS     = 64,
    parameter int COL_BITS = 8,
    parameter int ROW_BITS = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         do_write,
    input  logic [AW-1:0]                w_adr,
    input  logic [DW-1:0]                w_data,
    input  logic [AW-1:0]                r_adr,
    output logic [DW-1:0]                read_data,
    output logic                         chbuf_we,
    output logic [ROW_BITS+COL_BITS-1:0] chbuf_adr,
    output logic [7:0]                   chbuf_data,
    output logic                         busy
);

    localparam int AB = ROW_BITS + COL_BITS;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [AW-1:0] A_CUR  = AW'(0);
    localparam logic [AW-1:0] A_DATA = AW'(1);
    localparam logic [AW-1:0] A_FILL = AW'(2);
    localparam logic [AW-1:0] A_STAT = AW'(3);

    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);

    logic [0:0]          state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] frow_q, frow_d;
    logic [COL_BITS-1:0] fcol_q, fcol_d;
    logic [7:0]          fch_q, fch_d;
    logic                we_q, we_d;
    logic [AB-1:0]       adr_q, adr_d;
    logic [7:0]          data_q, data_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                drop_q, drop_d;
    logic                range_q, range_d;

    logic                wr_cur, wr_dat, wr_fil, wr_sta;
    logic                busy_w;
    logic [COL_BITS-1:0] wcol;
    logic [ROW_BITS-1:0] wrow;
    logic [ROW_BITS-1:0] nl_row;
    logic [7:0]          ch;

    assign busy_w = (state_q == S_FILL);
    assign wr_cur = do_write && (w_adr == A_CUR);
    assign wr_dat = do_write && (w_adr == A_DATA);
    assign wr_fil = do_write && (w_adr == A_FILL);
    assign wr_sta = do_write && (w_adr == A_STAT);
    assign wcol   = w_data[COL_BITS-1:0];
    assign wrow   = w_data[AB-1:COL_BITS];
    assign ch     = w_data[7:0];
    assign nl_row = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        frow_d  = frow_q;
        fcol_d  = fcol_q;
        fch_d   = fch_q;
        we_d    = 1'b0;
        adr_d   = adr_q;
        data_d  = data_q;
        drop_d  = drop_q;
        range_d = range_q;

        // Clear first so a same-cycle set overrides it
        if (wr_sta && w_data[1]) drop_d = 1'b0;
        if (wr_sta && w_data[2]) range_d = 1'b0;

        if (busy_w) begin
            if (wr_cur || wr_dat || wr_fil) drop_d = 1'b1;
            we_d   = 1'b1;
            adr_d  = {frow_q, fcol_q};
            data_d = fch_q;
            if (fcol_q == COL_LAST) begin
                fcol_d = '0;
                if (frow_q == ROW_LAST) begin
                    frow_d  = '0;
                    state_d = S_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    frow_d = frow_q + 1'b1;
                end
            end else begin
                fcol_d = fcol_q + 1'b1;
            end
        end else if (wr_cur) begin
            if (int'(wcol) < COLS && int'(wrow) < ROWS) begin
                row_d = wrow;
                col_d = wcol;
            end else begin
                range_d = 1'b1;
            end
        end else if (wr_dat) begin
            if (ch == 8'h0A) begin
                col_d = '0;
                row_d = nl_row;
            end else if (ch == 8'h0D) begin
                col_d = '0;
            end else begin
                we_d   = 1'b1;
                adr_d  = {row_q, col_q};
                data_d = ch;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = nl_row;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end else if (wr_fil) begin
            state_d = S_FILL;
            fch_d   = ch;
            frow_d  = '0;
            fcol_d  = '0;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (r_adr == A_CUR) begin
            rdata_d = DW'({row_q, col_q});
        end else if (r_adr == A_STAT) begin
            rdata_d = DW'({range_q, drop_q, busy_w});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            frow_q  <= '0;
            fcol_q  <= '0;
            fch_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            drop_q  <= 1'b0;
            range_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            frow_q  <= frow_d;
            fcol_q  <= fcol_d;
            fch_q   <= fch_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            drop_q  <= drop_d;
            range_q <= range_d;
        end
    end

    assign read_data  = rdata_q;
    assign chbuf_we   = we_q;
    assign chbuf_adr  = adr_q;
    assign chbuf_data = data_q;
    assign busy       = busy_w;

endmodule

// File: tb/tb_fsmc_text_console.sv
// Directed bench for fsmc_text_console: cursor, CR/LF, range,
// fill engine, drop during fill and reset mid-fill.
module tb_fsmc_text_console;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        do_write = 1'b0;
    logic [7:0]  w_adr = '0;
    logic [15:0] w_data = '0;
    logic [7:0]  r_adr = '0;
    logic [15:0] read_data;
    logic        chbuf_we;
    logic [13:0] chbuf_adr;
    logic [7:0]  chbuf_data;
    logic        busy;

    int tests = 0;
    int fails = 0;

    int          pcnt = 0;
    int          bad_data = 0;
    int          bad_col = 0;
    logic        in_fill = 1'b0;
    logic [7:0]  fill_exp = '0;
    logic [13:0] last_adr = '0;
    logic [13:0] first_adr = '0;

    always #5 clk = ~clk;

    fsmc_text_console dut (
        .clk       (clk),
        .rst       (rst),
        .do_write  (do_write),
        .w_adr     (w_adr),
        .w_data    (w_data),
        .r_adr     (r_adr),
        .read_data (read_data),
        .chbuf_we  (chbuf_we),
        .chbuf_adr (chbuf_adr),
        .chbuf_data(chbuf_data),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (chbuf_we) begin
            if (pcnt == 0) first_adr = chbuf_adr;
            pcnt = pcnt + 1;
            last_adr = chbuf_adr;
            if (in_fill && chbuf_data !== fill_exp) bad_data = bad_data + 1;
            if (chbuf_adr[7:0] >= 8'd160) bad_col = bad_col + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        do_write = 1'b1;
        w_adr    = a;
        w_data   = d;
        @(negedge clk);
        do_write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] d);
        @(negedge clk);
        r_adr = a;
        @(negedge clk);
        d = read_data;
    endtask

    logic [15:0] rv;
    int          snap;
    int          cyc;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_we", chbuf_we, 0);
        chk("rst_adr", chbuf_adr, 0);
        chk("rst_data", chbuf_data, 0);
        chk("rst_rdata", read_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        rd(8'h03, rv);
        chk("rst_status", rv, 16'h0000);
        pcnt = 0;

        wr(8'h01, 16'h0041);
        chk("A_we", chbuf_we, 1);
        chk("A_adr", chbuf_adr, 14'h0000);
        chk("A_data", chbuf_data, 8'h41);
        wr(8'h01, 16'h0042);
        chk("B_adr", chbuf_adr, 14'h0001);
        chk("B_data", chbuf_data, 8'h42);
        @(negedge clk);
        chk("B_we_drop", chbuf_we, 0);
        rd(8'h00, rv);
        chk("cur_after_AB", rv, 16'h0002);
        chk("pulses_AB", pcnt, 2);

        wr(8'h00, 16'h059F);
        wr(8'h01, 16'h0058);
        chk("X_adr", chbuf_adr, 14'h059F);
        chk("X_data", chbuf_data, 8'h58);
        rd(8'h00, rv);
        chk("cur_6_0", rv, 16'h0600);

        wr(8'h00, 16'h3F9F);
        wr(8'h01, 16'h005A);
        chk("Z_adr", chbuf_adr, 14'h3F9F);
        rd(8'h00, rv);
        chk("cur_wrap", rv, 16'h0000);

        wr(8'h00, 16'h030A);
        snap = pcnt;
        wr(8'h01, 16'h000D);
        chk("cr_we", chbuf_we, 0);
        rd(8'h00, rv);
        chk("cur_cr", rv, 16'h0300);
        wr(8'h01, 16'h000A);
        chk("lf_we", chbuf_we, 0);
        rd(8'h00, rv);
        chk("cur_lf", rv, 16'h0400);
        chk("crlf_pulses", pcnt, snap);

        wr(8'h00, 16'h02C8);
        rd(8'h00, rv);
        chk("range_cur", rv, 16'h0400);
        rd(8'h03, rv);
        chk("range_stat", rv, 16'h0004);
        wr(8'h05, 16'hFFFF);
        rd(8'h05, rv);
        chk("unmapped_rd", rv, 16'h0000);
        wr(8'h03, 16'h0004);
        rd(8'h03, rv);
        chk("range_clr", rv, 16'h0000);

        pcnt = 0;
        bad_data = 0;
        bad_col = 0;
        fill_exp = 8'h20;
        in_fill = 1'b1;
        wr(8'h02, 16'h0020);
        chk("fill_busy", busy, 1);
        wr(8'h01, 16'h0055);
        rd(8'h03, rv);
        chk("drop_stat", rv, 16'h0003);
        wr(8'h03, 16'h0002);
        rd(8'h03, rv);
        chk("drop_clr", rv, 16'h0001);
        cyc = 0;
        while (busy && cyc < 20000) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
        chk("fill_done_in_time", busy, 0);
        @(negedge clk);
        in_fill = 1'b0;
        chk("fill_pulses", pcnt, 10240);
        chk("fill_first", first_adr, 14'h0000);
        chk("fill_last", last_adr, 14'h3F9F);
        chk("fill_bad_data", bad_data, 0);
        chk("fill_bad_col", bad_col, 0);
        chk("fill_we_end", chbuf_we, 0);
        rd(8'h00, rv);
        chk("fill_cur", rv, 16'h0000);

        pcnt = 0;
        wr(8'h00, 16'h0105);
        wr(8'h02, 16'h002E);
        cyc = 0;
        while (pcnt < 500 && cyc < 2000) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
        chk("reach_500", pcnt >= 500, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_fill_we", chbuf_we, 0);
        chk("rst_fill_busy", busy, 0);
        rst = 1'b0;
        snap = pcnt;
        repeat (20) @(negedge clk);
        chk("rst_fill_nopulse", pcnt, snap);
        rd(8'h03, rv);
        chk("rst_fill_stat", rv, 16'h0000);
        rd(8'h00, rv);
        chk("rst_fill_cur", rv, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
